// File: rtl/control_fsm_pkg.sv
// rtl/control_fsm_pkg.sv - shared types and constants for the multicycle control FSM
package control_fsm_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_CMP = 4'b1010;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/control_fsm_cond_unit.sv
// rtl/control_fsm_cond_unit.sv - ARM condition-code evaluation against NZCV flags
module cond_unit
  import control_fsm_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v;
  assign {n, z, c, v} = Flags;

  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = ~(n ^ v);
      COND_LT: CondEx = n ^ v;
      COND_GT: CondEx = ~z & ~(n ^ v);
      COND_LE: CondEx = z | (n ^ v);
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - multicycle ARM control FSM with condition latch and NZCV register
module control_fsm
  import control_fsm_pkg::*;
#(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  output logic       ALUOp,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [3:0] Flags,
  output logic [3:0] State
);

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       condexr_q, condexr_d;
  logic       cond_ex;

  logic ir_write, next_pc, reg_w, mem_w, branch;

  cond_unit u_cond (
    .Cond   (Cond),
    .Flags  (flags_q),
    .CondEx (cond_ex)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      flags_q   <= FLAG_RESET;
      condexr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      condexr_q <= condexr_d;
    end
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        case (Op)
          OP_DP:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
          OP_MEM:  state_d = MEMADR;
          OP_BR:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MEMWB;
      EXECUTER,
      EXECUTEI: state_d = (Funct[4:1] == CMD_CMP) ? FETCH : ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  always_comb begin
    ALUOp     = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ir_write  = 1'b0;
    next_pc   = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    branch    = 1'b0;
    case (state_q)
      FETCH: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_write  = 1'b1;
        next_pc   = 1'b1;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      EXECUTER: ALUOp = 1'b1;
      EXECUTEI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      ALUWB:    reg_w = 1'b1;
      BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // The condition is frozen at DECODE so the instruction's own flag update cannot alter its writes.
  assign condexr_d = (state_q == DECODE) ? cond_ex : condexr_q;

  always_comb begin
    flags_d = flags_q;
    if ((state_q == EXECUTER || state_q == EXECUTEI) && condexr_q) begin
      if (FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
      if (FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  assign IRWrite  = ir_write & ~reset;
  assign RegWrite = reg_w & condexr_q & ~reset;
  assign MemWrite = mem_w & condexr_q & ~reset;
  assign PCWrite  = (next_pc | ((branch | (reg_w & (Rd == 4'd15))) & condexr_q)) & ~reset;
  assign Flags    = flags_q;
  assign State    = state_q;

endmodule

// File: tb/tb_control_fsm.sv
// tb/tb_control_fsm.sv - randomized self-checking bench for control_fsm against an instruction-level model
module tb_control_fsm;
  import control_fsm_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd, cond, alu_flags;
  logic [1:0] flag_w;
  logic       alu_op, ir_write, adr_src, pc_write, reg_write, mem_write;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [3:0] flags, state;

  int         n_checks = 0;
  int         n_err = 0;
  logic [3:0] m_flags;
  logic [11:0] ctrl_vec;

  always #5 clk = ~clk;

  control_fsm dut (
    .clk(clk), .reset(reset), .Op(op), .Funct(funct), .Rd(rd), .Cond(cond),
    .ALUFlags(alu_flags), .FlagW(flag_w), .ALUOp(alu_op), .IRWrite(ir_write),
    .AdrSrc(adr_src), .PCWrite(pc_write), .RegWrite(reg_write), .MemWrite(mem_write),
    .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b), .ResultSrc(result_src),
    .Flags(flags), .State(state)
  );

  assign ctrl_vec = {alu_op, ir_write, adr_src, pc_write, reg_write, mem_write,
                     alu_src_a, alu_src_b, result_src};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic cond_holds(input logic [3:0] c_in, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (c_in)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [11:0] exp_ctrl(input state_t s, input logic ok, input logic [3:0] r);
    logic aluop, irw, adr, npc, regw, memw, br;
    logic [1:0] sa, sb, rs;
    {aluop, irw, adr, npc, regw, memw, br} = '0;
    {sa, sb, rs} = '0;
    case (s)
      FETCH:    begin sa = 2'd1; sb = 2'd2; rs = 2'd2; irw = 1'b1; npc = 1'b1; end
      DECODE:   begin sa = 2'd1; sb = 2'd2; rs = 2'd2; end
      MEMADR:   sb = 2'd1;
      MEMREAD:  adr = 1'b1;
      MEMWB:    begin rs = 2'd1; regw = 1'b1; end
      MEMWRITE: begin adr = 1'b1; memw = 1'b1; end
      EXECUTER: aluop = 1'b1;
      EXECUTEI: begin sb = 2'd1; aluop = 1'b1; end
      ALUWB:    regw = 1'b1;
      BRANCH:   begin sa = 2'd2; sb = 2'd1; rs = 2'd2; br = 1'b1; end
      default: ;
    endcase
    return {aluop, irw, adr, npc | ((br | (regw && r == 4'd15)) & ok),
            regw & ok, memw & ok, sa, sb, rs};
  endfunction

  // Enter at FETCH; leave at the start of the following FETCH.
  task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                           input logic [3:0] c, input logic [3:0] af, input logic [1:0] fw);
    state_t seq[$];
    logic   ok;
    op = o; funct = f; rd = r; cond = c; alu_flags = af; flag_w = fw;
    #1;
    ok = cond_holds(c, m_flags);
    seq = {FETCH, DECODE};
    case (o)
      2'b00: begin
        seq.push_back(f[5] ? EXECUTEI : EXECUTER);
        if (f[4:1] != 4'b1010) seq.push_back(ALUWB);
      end
      2'b01: begin
        seq.push_back(MEMADR);
        if (f[0]) begin seq.push_back(MEMREAD); seq.push_back(MEMWB); end
        else seq.push_back(MEMWRITE);
      end
      2'b10: seq.push_back(BRANCH);
      default: ;
    endcase
    foreach (seq[i]) begin
      check("state", 32'(state), 32'(seq[i]));
      check("ctrl", 32'(ctrl_vec), 32'(exp_ctrl(seq[i], ok, r)));
      check("flags", 32'(flags), 32'(m_flags));
      @(posedge clk); #1;
      if ((seq[i] == EXECUTER || seq[i] == EXECUTEI) && ok) begin
        if (fw[1]) m_flags[3:2] = af[3:2];
        if (fw[0]) m_flags[1:0] = af[1:0];
      end
    end
  endtask

  task automatic reset_in_store();
    op = 2'b01; funct = 6'b011000; rd = 4'd3; cond = 4'b1110;
    repeat (3) begin @(posedge clk); #1; end
    check("st_state", 32'(state), 32'(MEMWRITE));
    check("st_memw", 32'(mem_write), 32'd1);
    reset = 1'b1; #1;
    check("rst_memw", 32'(mem_write), 32'd0);
    check("rst_wen", 32'({ir_write, pc_write, reg_write}), 32'd0);
    @(posedge clk); #1;
    m_flags = 4'b0000;
    check("rst_state", 32'(state), 32'(FETCH));
    check("rst_flags", 32'(flags), 32'(m_flags));
    reset = 1'b0; #1;
    check("rst_irw", 32'(ir_write), 32'd1);
  endtask

  initial begin
    reset = 1'b1; op = '0; funct = '0; rd = '0; cond = '0; alu_flags = '0; flag_w = '0;
    m_flags = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_state", 32'(state), 32'(FETCH));
    check("rst_hold_wen", 32'({ir_write, pc_write, reg_write, mem_write}), 32'd0);
    reset = 1'b0; #1;
    check("rel_state", 32'(state), 32'(FETCH));
    check("rel_irw", 32'(ir_write), 32'd1);
    check("rel_pcw", 32'(pc_write), 32'd1);
    check("rel_flags", 32'(flags), 32'd0);

    run_instr(2'b01, 6'b011001, 4'd2, 4'b1110, 4'h0, 2'b00);   // LDR
    run_instr(2'b00, 6'b000101, 4'd1, 4'b1110, 4'b0100, 2'b11); // SUBS -> Z
    check("subs_flags", 32'(flags), 32'h4);
    run_instr(2'b00, 6'b001000, 4'd4, 4'b0000, 4'h0, 2'b00);   // ADDEQ
    run_instr(2'b00, 6'b000101, 4'd1, 4'b1110, 4'b0000, 2'b11); // clear Z
    run_instr(2'b00, 6'b001001, 4'd5, 4'b0001, 4'b0100, 2'b11); // ADDSNE
    check("addsne_flags", 32'(flags), 32'h4);
    run_instr(2'b00, 6'b000101, 4'd1, 4'b1110, 4'b0000, 2'b11);
    run_instr(2'b10, 6'b100000, 4'd0, 4'b0000, 4'h0, 2'b00);   // BEQ not taken
    run_instr(2'b00, 6'b000101, 4'd1, 4'b1110, 4'b0100, 2'b11);
    run_instr(2'b10, 6'b100000, 4'd0, 4'b0000, 4'h0, 2'b00);   // BEQ taken
    run_instr(2'b00, 6'b010101, 4'd0, 4'b1110, 4'b1001, 2'b11); // CMP
    run_instr(2'b00, 6'b101000, 4'd15, 4'b1110, 4'h0, 2'b00);  // ADD to PC
    run_instr(2'b11, 6'b000000, 4'd0, 4'b1110, 4'h0, 2'b00);   // undefined
    reset_in_store();

    for (int k = 0; k < 200; k++) begin
      run_instr(2'($urandom), 6'($urandom), ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom),
                4'($urandom), 4'($urandom), 2'($urandom));
    end
    check("final_state", 32'(state), 32'(FETCH));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
